// File: rtl/apb_uart_regif.sv
// APB3 register front-end for the UART core.
// Holds UART config locally and handshakes TX/RX words with wait states.
module apb_uart_regif #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter int                    TIMEOUT    = 16,
    parameter logic [15:0]           BAUD_RST   = 16'd27
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic                  PSELx,
    input  logic                  PENABLE,
    input  logic                  PWRITE,
    input  logic [ADDR_WIDTH-1:0] PADDR,
    input  logic [DATA_WIDTH-1:0] PWDATA,
    output logic [DATA_WIDTH-1:0] PRDATA,
    output logic                  PREADY,
    output logic                  PSLVERR,
    output logic                  tx_valid,
    output logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_ready,
    output logic                  rx_req,
    input  logic                  rx_valid,
    input  logic [DATA_WIDTH-1:0] rx_data,
    input  logic                  rx_avail,
    input  logic                  uart_error,
    output logic [15:0]           baud_div,
    output logic [1:0]            frame_cfg,
    output logic [1:0]            parity_cfg,
    output logic                  stop_cfg
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        TX_WAIT,
        RX_WAIT,
        RESP
    } state_t;

    state_t                state, state_n;
    logic [CW-1:0]         cnt;
    logic                  sticky;
    logic [4:0]            off;
    logic                  access;
    logic                  base_ok;
    logic                  dec_err;
    logic                  tx_hit;
    logic                  rx_hit;
    logic                  timed_out;
    logic [DATA_WIDTH-1:0] rd_val;
    logic                  ld_resp;
    logic                  resp_err;
    logic [DATA_WIDTH-1:0] resp_data;
    logic                  start_tx;
    logic                  wr_cfg;
    logic                  clr_sticky;

    assign off       = PADDR[4:0];
    assign access    = PSELx & PENABLE;
    assign base_ok   = PADDR[ADDR_WIDTH-1:5] == BASE_ADDR[ADDR_WIDTH-1:5];
    assign timed_out = cnt == CW'(TIMEOUT - 1);

    always_comb begin
        dec_err = !base_ok
                | (off[1:0] != 2'd0)
                | (off > 5'h18)
                | (PWRITE & ((off == 5'h04) | (off == 5'h18)))
                | (!PWRITE & (off == 5'h00));
        tx_hit  = !dec_err & PWRITE & (off == 5'h00);
        rx_hit  = !dec_err & !PWRITE & (off == 5'h04);
    end

    always_comb begin
        rd_val = '0;
        case (off)
            5'h08:   rd_val[15:0] = baud_div;
            5'h0C:   rd_val[1:0]  = frame_cfg;
            5'h10:   rd_val[1:0]  = parity_cfg;
            5'h14:   rd_val[0]    = stop_cfg;
            5'h18:   rd_val[2:0]  = {sticky, rx_avail, state == TX_WAIT};
            default: rd_val       = '0;
        endcase
    end

    always_comb begin
        state_n    = state;
        ld_resp    = 1'b0;
        resp_err   = 1'b0;
        resp_data  = '0;
        start_tx   = 1'b0;
        wr_cfg     = 1'b0;
        clr_sticky = 1'b0;
        unique case (state)
            IDLE: begin
                if (access) begin
                    unique case (1'b1)
                        dec_err: begin
                            state_n  = RESP;
                            ld_resp  = 1'b1;
                            resp_err = 1'b1;
                        end
                        tx_hit: begin
                            state_n  = TX_WAIT;
                            start_tx = 1'b1;
                        end
                        rx_hit: begin
                            state_n = RX_WAIT;
                        end
                        default: begin
                            state_n    = RESP;
                            ld_resp    = 1'b1;
                            resp_data  = PWRITE ? '0 : rd_val;
                            wr_cfg     = PWRITE;
                            clr_sticky = !PWRITE & (off == 5'h18);
                        end
                    endcase
                end
            end
            TX_WAIT: begin
                // A dropped select abandons the transfer silently.
                if (!PSELx) begin
                    state_n = IDLE;
                end else if (tx_ready) begin
                    state_n = RESP;
                    ld_resp = 1'b1;
                end else if (timed_out) begin
                    state_n  = RESP;
                    ld_resp  = 1'b1;
                    resp_err = 1'b1;
                end
            end
            RX_WAIT: begin
                if (!PSELx) begin
                    state_n = IDLE;
                end else if (rx_valid) begin
                    state_n   = RESP;
                    ld_resp   = 1'b1;
                    resp_data = rx_data;
                    resp_err  = uart_error;
                end else if (timed_out) begin
                    state_n  = RESP;
                    ld_resp  = 1'b1;
                    resp_err = 1'b1;
                end
            end
            RESP: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state      <= IDLE;
            cnt        <= '0;
            PREADY     <= 1'b0;
            PSLVERR    <= 1'b0;
            PRDATA     <= '0;
            tx_valid   <= 1'b0;
            tx_data    <= '0;
            rx_req     <= 1'b0;
            sticky     <= 1'b0;
            baud_div   <= BAUD_RST;
            frame_cfg  <= 2'd3;
            parity_cfg <= 2'd0;
            stop_cfg   <= 1'b0;
        end else begin
            state    <= state_n;
            PREADY   <= ld_resp;
            PSLVERR  <= ld_resp & resp_err;
            PRDATA   <= ld_resp ? resp_data : '0;
            tx_valid <= state_n == TX_WAIT;
            rx_req   <= state_n == RX_WAIT;
            if ((state == TX_WAIT || state == RX_WAIT) && state_n == state)
                cnt <= cnt + CW'(1);
            else
                cnt <= '0;
            if (start_tx)
                tx_data <= PWDATA;
            if (ld_resp && resp_err)
                sticky <= 1'b1;
            else if (clr_sticky)
                sticky <= 1'b0;
            if (wr_cfg) begin
                case (off)
                    5'h08:   baud_div   <= PWDATA[15:0];
                    5'h0C:   frame_cfg  <= PWDATA[1:0];
                    5'h10:   parity_cfg <= PWDATA[1:0];
                    5'h14:   stop_cfg   <= PWDATA[0];
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_apb_uart_regif.sv
// Randomised APB bench for apb_uart_regif.
// Expected responses come from a transaction-level model of the register map.
module tb_apb_uart_regif;

    localparam int          DW      = 32;
    localparam int          AW      = 32;
    localparam logic [31:0] BASE    = 32'h4000_1000;
    localparam int          TIMEOUT = 16;

    logic          PCLK = 1'b0;
    logic          PRESET;
    logic          PSELx, PENABLE, PWRITE;
    logic [AW-1:0] PADDR;
    logic [DW-1:0] PWDATA, PRDATA;
    logic          PREADY, PSLVERR;
    logic          tx_valid, tx_ready;
    logic [DW-1:0] tx_data;
    logic          rx_req, rx_valid;
    logic [DW-1:0] rx_data;
    logic          rx_avail, uart_error;
    logic [15:0]   baud_div;
    logic [1:0]    frame_cfg, parity_cfg;
    logic          stop_cfg;

    int n_vec = 0;
    int n_bad = 0;

    logic [15:0] m_baud;
    logic [1:0]  m_frame, m_parity;
    logic        m_stop, m_sticky;

    apb_uart_regif #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .BASE_ADDR (BASE),
        .TIMEOUT   (TIMEOUT),
        .BAUD_RST  (16'd27)
    ) dut (
        .PCLK      (PCLK),
        .PRESET    (PRESET),
        .PSELx     (PSELx),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PADDR     (PADDR),
        .PWDATA    (PWDATA),
        .PRDATA    (PRDATA),
        .PREADY    (PREADY),
        .PSLVERR   (PSLVERR),
        .tx_valid  (tx_valid),
        .tx_data   (tx_data),
        .tx_ready  (tx_ready),
        .rx_req    (rx_req),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .rx_avail  (rx_avail),
        .uart_error(uart_error),
        .baud_div  (baud_div),
        .frame_cfg (frame_cfg),
        .parity_cfg(parity_cfg),
        .stop_cfg  (stop_cfg)
    );

    always #5 PCLK = ~PCLK;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_baud   = 16'd27;
        m_frame  = 2'd3;
        m_parity = 2'd0;
        m_stop   = 1'b0;
        m_sticky = 1'b0;
    endtask

    task automatic chk_cfg(input string tag);
        chk(tag, {baud_div, frame_cfg, parity_cfg, stop_cfg},
            {m_baud, m_frame, m_parity, m_stop});
    endtask

    task automatic chk_reset_outs();
        chk("rst_rsp", {PREADY, PSLVERR, PRDATA}, 0);
        chk("rst_hs", {tx_valid, rx_req, tx_data}, 0);
        chk_cfg("rst_cfg");
    endtask

    // d: cycles the UART holds off before its handshake
    task automatic xfer(input bit wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input int d,
                        input logic [31:0] rxd, input bit rxe,
                        input bit avail);
        int          off;
        bit          ill, is_tx, is_rx, exp_err, done;
        int          exp_lat, k;
        logic [31:0] exp_data;
        off   = int'(addr[4:0]);
        ill   = ((addr >> 5) != (BASE >> 5)) || (off % 4 != 0)
             || (off > 24) || (wr && (off == 4 || off == 24))
             || (!wr && off == 0);
        is_tx = !ill && wr && off == 0;
        is_rx = !ill && !wr && off == 4;
        exp_lat  = 1;
        exp_err  = ill;
        exp_data = 0;
        if (is_tx || is_rx) begin
            if (d + 1 <= TIMEOUT) begin
                exp_lat = d + 2;
                exp_err = is_rx && rxe;
                if (is_rx) exp_data = rxd;
            end else begin
                exp_lat = TIMEOUT + 1;
                exp_err = 1'b1;
            end
        end else if (!ill && !wr) begin
            case (off)
                8:       exp_data = 32'(m_baud);
                12:      exp_data = 32'(m_frame);
                16:      exp_data = 32'(m_parity);
                20:      exp_data = 32'(m_stop);
                24:      exp_data = {29'd0, m_sticky, avail, 1'b0};
                default: exp_data = 0;
            endcase
        end
        @(negedge PCLK);
        rx_avail = avail;
        PSELx    = 1'b1;
        PENABLE  = 1'b0;
        PADDR    = addr;
        PWRITE   = wr;
        PWDATA   = wdata;
        @(negedge PCLK);
        PENABLE = 1'b1;
        k    = 0;
        done = 0;
        while (!done) begin
            @(negedge PCLK);
            k++;
            if (PREADY) begin
                chk("latency", k, exp_lat);
                chk("prdata", PRDATA, exp_data);
                chk("pslverr", PSLVERR, exp_err);
                chk("hs_drop", {tx_valid, rx_req}, 0);
                done = 1;
            end else if (k > TIMEOUT + 4) begin
                chk("no_pready", k, exp_lat);
                done = 1;
            end else begin
                chk("rsp_idle", {31'd0, PSLVERR, PRDATA}, 0);
                chk("tx_valid", tx_valid, is_tx);
                chk("rx_req", rx_req, is_rx);
                if (is_tx) chk("tx_data", tx_data, wdata);
                tx_ready   = is_tx && (k == d + 1);
                rx_valid   = is_rx && (k == d + 1);
                rx_data    = rx_valid ? rxd : $urandom;
                uart_error = rx_valid ? rxe : 1'($urandom);
            end
        end
        PSELx    = 1'b0;
        PENABLE  = 1'b0;
        tx_ready = 1'b0;
        rx_valid = 1'b0;
        if (exp_err)
            m_sticky = 1'b1;
        else if (!wr && off == 24)
            m_sticky = 1'b0;
        if (!ill && wr) begin
            case (off)
                8:       m_baud   = wdata[15:0];
                12:      m_frame  = wdata[1:0];
                16:      m_parity = wdata[1:0];
                20:      m_stop   = wdata[0];
                default: ;
            endcase
        end
        chk_cfg("cfg");
    endtask

    task automatic abort_tx();
        @(negedge PCLK);
        PSELx   = 1'b1;
        PENABLE = 1'b0;
        PADDR   = BASE;
        PWRITE  = 1'b1;
        PWDATA  = 32'h5A5A_0001;
        @(negedge PCLK);
        PENABLE = 1'b1;
        repeat (3) @(negedge PCLK);
        chk("abort_busy", tx_valid, 1);
        #2 PRESET = 1'b1;
        #1 model_reset();
        chk_reset_outs();
        @(negedge PCLK);
        PRESET  = 1'b0;
        PSELx   = 1'b0;
        PENABLE = 1'b0;
        repeat (2) begin
            @(negedge PCLK);
            chk("abort_nordy", PREADY, 0);
        end
    endtask

    initial begin
        PRESET     = 1'b1;
        PSELx      = 1'b0;
        PENABLE    = 1'b0;
        PWRITE     = 1'b0;
        PADDR      = '0;
        PWDATA     = '0;
        tx_ready   = 1'b0;
        rx_valid   = 1'b0;
        rx_data    = '0;
        rx_avail   = 1'b0;
        uart_error = 1'b0;
        model_reset();
        repeat (2) @(negedge PCLK);
        chk_reset_outs();
        PRESET = 1'b0;

        xfer(1, BASE + 32'h08, 32'hFFFF_1234, 0, 0, 0, 0);
        xfer(0, BASE + 32'h08, 0, 0, 0, 0, 0);
        xfer(1, BASE + 32'h00, 32'hA5, 3, 0, 0, 0);
        xfer(0, BASE + 32'h04, 0, 1, 32'h3C, 1, 1);
        xfer(0, BASE + 32'h18, 0, 0, 0, 0, 1);
        xfer(0, BASE + 32'h18, 0, 0, 0, 0, 0);
        xfer(1, BASE + 32'h00, 32'h77, TIMEOUT, 0, 0, 0);
        xfer(1, BASE + 32'h00, 32'h78, TIMEOUT - 1, 0, 0, 0);
        xfer(0, BASE + 32'h04, 0, TIMEOUT, 32'h11, 0, 0);
        xfer(1, BASE + 32'h0C, 32'h1, 0, 0, 0, 0);
        xfer(1, BASE + 32'h10, 32'h2, 0, 0, 0, 0);
        xfer(1, BASE + 32'h14, 32'h3, 0, 0, 0, 0);
        xfer(0, BASE + 32'h00, 0, 0, 0, 0, 0);
        xfer(1, BASE + 32'h18, 32'h7, 0, 0, 0, 0);
        xfer(0, BASE + 32'h1C, 0, 0, 0, 0, 0);
        xfer(1, BASE + 32'h09, 32'h9, 0, 0, 0, 0);
        xfer(1, BASE + 32'h1008, 32'h4321, 0, 0, 0, 0);
        xfer(0, BASE + 32'h18, 0, 0, 0, 0, 1);

        for (int i = 0; i < 300; i++) begin
            logic [31:0] a;
            int          d;
            a = BASE + $urandom_range(0, 31);
            if ($urandom_range(0, 7) == 0)
                a = a ^ (32'd1 << $urandom_range(5, 31));
            if ($urandom_range(0, 3) == 0)
                d = $urandom_range(0, TIMEOUT + 2);
            else
                d = $urandom_range(0, 3);
            xfer(1'($urandom), a, $urandom, d, $urandom,
                 1'($urandom), 1'($urandom));
        end

        abort_tx();
        xfer(0, BASE + 32'h08, 0, 0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/apb_uart_regif.md
# apb_uart_regif

Parametrised APB3 slave front-end for the UART. It replaces the combinational decode-and-forward slave with a registered interface. It holds the UART configuration registers locally, runs valid/ready handshakes with the TX and RX paths, inserts wait states, and flags errors for unmapped, illegal or timed-out accesses. It sits between the APB master (bus fabric) and the UART core.

## Interface
- DATA_WIDTH, 32: PWDATA/PRDATA/tx_data/rx_data width (≥16)
- ADDR_WIDTH, 32: PADDR width (≥8)
- BASE_ADDR, 0: block base; PADDR[ADDR_WIDTH-1:5] must equal BASE_ADDR[ADDR_WIDTH-1:5]
- TIMEOUT, 16: max cycles waiting on a UART handshake (≥2)
- BAUD_RST, 16'd27: reset value of baud divisor
- PCLK  in  1  clock
- PRESET  in  1  asynchronous reset, active-high
- PSELx, PENABLE, PWRITE  in  1  APB control
- PADDR  in  ADDR_WIDTH  address
- PWDATA  in  DATA_WIDTH  write data
- PRDATA  out  DATA_WIDTH  read data, registered
- PREADY, PSLVERR  out  1  registered APB response
- tx_valid  out  1  TX data offered to UART
- tx_data  out  DATA_WIDTH  TX payload, held while tx_valid
- tx_ready  in  1  UART accepts TX data
- rx_req  out  1  request one RX word
- rx_valid  in  1  rx_data valid
- rx_data  in  DATA_WIDTH  RX payload
- rx_avail  in  1  UART RX holds data (status only)
- uart_error  in  1  frame/parity error on current RX word
- baud_div  out  16  baud divisor register
- frame_cfg  out  2  data bits − 5
- parity_cfg  out  2  0 none, 1 odd, 2 even
- stop_cfg  out  1  0 one stop bit, 1 two stop bits

## Operation
- Register offsets (PADDR[4:0]): 0x00 trans_data (W), 0x04 recv_data (R), 0x08 baud (RW), 0x0C frame (RW), 0x10 parity (RW), 0x14 stop_bits (RW), 0x18 status (R).
- Status bits: [0] tx busy (state TX_WAIT), [1] rx_avail, [2] sticky error. The sticky error is set on any PSLVERR=1 response and cleared by a status read. The returned value is pre-clear.
- Config writes take PWDATA low bits; upper bits are ignored. Config reads return the value zero-extended.
- Error (PSLVERR=1, no state change, PRDATA=0) on:
  - base mismatch
  - PADDR[1:0]≠0
  - offset >0x18
  - write to recv_data or status
  - read of trans_data
- FSM states: IDLE, TX_WAIT, RX_WAIT, RESP.
- IDLE: on PSELx&PENABLE, decode:
  - trans_data write → TX_WAIT; latch PWDATA into tx_data.
  - recv_data read → RX_WAIT.
  - all else → RESP; config/status/error result is computed this cycle.
- TX_WAIT: tx_valid=1. On tx_ready → RESP, ok.
- RX_WAIT: rx_req=1. On rx_valid → RESP; PRDATA=rx_data, PSLVERR=uart_error.
- In either wait state, a counter reaching TIMEOUT cycles → RESP with PSLVERR=1, PRDATA=0; tx_valid/rx_req drop.
- RESP: PREADY=1 for exactly one cycle → IDLE.
- If PSELx falls in TX_WAIT/RX_WAIT (a protocol violation), go to IDLE, drop tx_valid/rx_req, and generate no response.

## Timing
- Reset values:
  - PREADY=0, PSLVERR=0, PRDATA=0
  - tx_valid=0, tx_data=0, rx_req=0
  - baud_div=BAUD_RST, frame_cfg=3 (8 bits), parity_cfg=0, stop_cfg=0
  - sticky error=0, state IDLE, counter 0
- PRESET mid-transfer aborts immediately; no PREADY is issued.
- Access cycle T0 = first cycle with PSELx&PENABLE.
- Config, status and error accesses: PREADY=1 at T1 (one wait state). Config registers update at the T1 edge.
- TX: tx_valid=1 from T1. If tx_ready is seen at Tk, PREADY=1 at Tk+1 and tx_valid=0 at Tk+1. Minimum latency is PREADY at T2.
- RX: same as TX, using rx_req/rx_valid. rx_data and uart_error are sampled on the rx_valid cycle.
- Timeout: if there is no handshake in T1..T(TIMEOUT), PREADY=1 with PSLVERR=1 at T(TIMEOUT+1).
- PRDATA and PSLVERR are valid only while PREADY=1; otherwise they are 0.
- The block ignores PSELx&PENABLE in the RESP cycle, so back-to-back transfers start no earlier than the cycle after PREADY.

## Test plan
- Reset: assert PRESET asynchronously → all outputs at reset values, baud_div=27, frame_cfg=3.
- Config: write 0x08=0x1234, then read 0x08 → PREADY at T1 each time, read data 0x00001234, baud_div=0x1234, PSLVERR=0.
- TX: write 0x00=0xA5 with tx_ready held low 3 cycles → tx_valid T1..T4, tx_data=0xA5, PREADY at T5, PSLVERR=0.
- RX error: read 0x04, rx_valid at T2 with rx_data=0x3C and uart_error=1 → PREADY at T3, PRDATA=0x3C, PSLVERR=1. A following status read returns bit2=1; the next status read returns bit2=0.
- Timeout: TIMEOUT=16, write 0x00 with tx_ready never asserted → PREADY and PSLVERR at T17, tx_valid low from T17.
- Illegal accesses: read 0x00, write 0x18, access 0x1C, access 0x09 → each gets PREADY at T1 with PSLVERR=1; config outputs unchanged.
